// File: rtl/song_sequencer_if.sv
// Song sequencer bus: synchronous ROM read port plus the note-player control and
// note-complete handshake.
interface song_sequencer_if #(
    parameter int unsigned OCTAVE_BITS = 3,
    parameter int unsigned NOTE_BITS   = 3,
    parameter int unsigned LENGTH_BITS = 3,
    parameter int unsigned ADDR_BITS   = 8
);
    localparam int unsigned WORD_BITS = 2 + OCTAVE_BITS + NOTE_BITS + LENGTH_BITS;

    logic [ADDR_BITS-1:0]   rom_addr;
    logic [WORD_BITS-1:0]   rom_data;
    logic                   snd_en;
    logic [OCTAVE_BITS-1:0] snd_octave;
    logic [NOTE_BITS-1:0]   snd_note;
    logic [LENGTH_BITS-1:0] snd_length;
    logic                   snd_mute;
    logic                   snd_over;

    modport master (
        output rom_addr,
        input  rom_data,
        output snd_en,
        output snd_octave,
        output snd_note,
        output snd_length,
        output snd_mute,
        input  snd_over
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        input  snd_en,
        input  snd_octave,
        input  snd_note,
        input  snd_length,
        input  snd_mute,
        output snd_over
    );
endinterface

// File: rtl/song_sequencer.sv
// Song sequencer: walks note words in a synchronous song ROM, hands each one to the note
// player and waits for its over flag, with a fixed silent gap between notes.
module song_sequencer #(
    parameter int unsigned OCTAVE_BITS = 3,
    parameter int unsigned NOTE_BITS   = 3,
    parameter int unsigned LENGTH_BITS = 3,
    parameter int unsigned ADDR_BITS   = 8,
    parameter int unsigned GAP_CYCLES  = 1000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 pause,
    input  logic [ADDR_BITS-1:0] song_base,
    song_sequencer_if.master     bus,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_BITS-1:0] cur_index
);
    localparam int unsigned NoteLsb = LENGTH_BITS;
    localparam int unsigned OctLsb  = LENGTH_BITS + NOTE_BITS;
    localparam int unsigned RestBit = OctLsb + OCTAVE_BITS;
    localparam int unsigned EndBit  = RestBit + 1;
    localparam int unsigned GapW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLatch,
        StPlay,
        StGap
    } state_e;

    state_e              state_q;
    logic [ADDR_BITS-1:0] base_q;
    logic [GapW-1:0]      gap_cnt_q;
    logic                 armed_q;
    logic                 word_end;
    logic                 gap_exit;

    assign bus.rom_addr = base_q + cur_index;
    assign word_end     = bus.rom_data[EndBit];
    assign gap_exit     = (gap_cnt_q == GapLast) && !pause;

    // done is decoded from the current state so it appears in the LATCH cycle that sees the
    // end word, one cycle ahead of the IDLE transition; stop suppresses it.
    assign done = !stop && (((state_q == StLatch) && word_end) ||
                            ((state_q == StGap) && gap_exit && (cur_index == '1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            base_q         <= '0;
            gap_cnt_q      <= '0;
            armed_q        <= 1'b0;
            busy           <= 1'b0;
            cur_index      <= '0;
            bus.snd_en     <= 1'b0;
            bus.snd_mute   <= 1'b0;
            bus.snd_octave <= '0;
            bus.snd_note   <= '0;
            bus.snd_length <= '0;
        end else if (stop) begin
            state_q      <= StIdle;
            armed_q      <= 1'b0;
            busy         <= 1'b0;
            bus.snd_en   <= 1'b0;
            bus.snd_mute <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        base_q    <= song_base;
                        cur_index <= '0;
                        busy      <= 1'b1;
                        state_q   <= StFetch;
                    end
                end
                StFetch: state_q <= StLatch;
                StLatch: begin
                    if (word_end) begin
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        bus.snd_octave <= bus.rom_data[OctLsb +: OCTAVE_BITS];
                        bus.snd_note   <= bus.rom_data[NoteLsb +: NOTE_BITS];
                        bus.snd_length <= bus.rom_data[0 +: LENGTH_BITS];
                        bus.snd_mute   <= bus.rom_data[RestBit];
                        bus.snd_en     <= 1'b1;
                        armed_q        <= 1'b0;
                        state_q        <= StPlay;
                    end
                end
                StPlay: begin
                    // The player's over flag is stale-high on the first enabled cycle, so it
                    // only counts once it has been seen low.
                    if (!bus.snd_over) begin
                        armed_q <= 1'b1;
                    end else if (armed_q) begin
                        armed_q      <= 1'b0;
                        bus.snd_en   <= 1'b0;
                        bus.snd_mute <= 1'b0;
                        gap_cnt_q    <= '0;
                        state_q      <= StGap;
                    end
                end
                StGap: begin
                    if (gap_cnt_q != GapLast) begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end else if (!pause) begin
                        if (cur_index == '1) begin
                            busy    <= 1'b0;
                            state_q <= StIdle;
                        end else begin
                            cur_index <= cur_index + 1'b1;
                            state_q   <= StFetch;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule
